// File: rtl/stab_sweep_if.sv
// Handshake bundle between the stability sweep scheduler and its controller/solver side.
// The slave modport is the scheduler view; the master modport is the controller/engine view.
interface stab_sweep_if #(
    parameter int IDX_W = 8
);
    logic             start;
    logic             abort;
    logic [IDX_W-1:0] npts;
    logic             solve_req;
    logic [1:0]       solve_type;
    logic [IDX_W-1:0] solve_idx;
    logic             solve_ack;
    logic             solve_done;
    logic             solve_ok;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       err_code;
    logic [IDX_W:0]   pts_done;

    modport slave (
        input  start, abort, npts, solve_ack, solve_done, solve_ok,
        output solve_req, solve_type, solve_idx, busy, done, error, err_code, pts_done
    );

    modport master (
        output start, abort, npts, solve_ack, solve_done, solve_ok,
        input  solve_req, solve_type, solve_idx, busy, done, error, err_code, pts_done
    );
endinterface

// File: rtl/stab_sweep_sched.sv
// Sequences DC, then AC/SP pairs per frequency point, on a shared solver engine.
// Handles retries on non-convergence, per-request timeout and abort; all outputs are registered.
module stab_sweep_sched #(
    parameter int IDX_W     = 8,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic clk,
    input  logic rst_n,
    stab_sweep_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0]  R_MAX    = RW'(MAX_RETRY);
    localparam logic [IDX_W:0] P_ONE    = 1;

    typedef enum logic [3:0] {
        S_IDLE, S_DC_REQ, S_DC_WAIT, S_AC_REQ, S_AC_WAIT,
        S_SP_REQ, S_SP_WAIT, S_FIN, S_ERR
    } state_t;

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_npts, w_npts_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic [RW-1:0]    r_retry, w_retry_next;
    logic [TW-1:0]    r_tcnt, w_tcnt_next;
    logic [IDX_W:0]   r_pts, w_pts_next;
    logic             r_error, w_error_next;
    logic [1:0]       r_err_code, w_err_code_next;
    logic             r_solve_req, r_busy, r_done;
    logic [1:0]       r_solve_type;
    logic [IDX_W:0]   w_idx_inc;
    logic             w_is_wait;

    assign w_idx_inc = {1'b0, r_idx} + P_ONE;
    assign w_is_wait = (r_state == S_DC_WAIT) || (r_state == S_AC_WAIT) || (r_state == S_SP_WAIT);

    always_comb begin
        w_state_next    = r_state;
        w_npts_next     = r_npts;
        w_idx_next      = r_idx;
        w_retry_next    = r_retry;
        w_tcnt_next     = r_tcnt;
        w_pts_next      = r_pts;
        w_error_next    = r_error;
        w_err_code_next = r_err_code;

        // Abort wins over every other event; ERR is already on its way out.
        if (bus.abort && r_state != S_IDLE && r_state != S_ERR) begin
            w_state_next    = S_ERR;
            w_err_code_next = 2'b11;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_state_next    = S_DC_REQ;
                        w_npts_next     = bus.npts;
                        w_idx_next      = '0;
                        w_retry_next    = '0;
                        w_tcnt_next     = '0;
                        w_pts_next      = '0;
                        w_error_next    = 1'b0;
                        w_err_code_next = 2'b00;
                    end
                end
                S_DC_REQ, S_AC_REQ, S_SP_REQ: begin
                    if (bus.solve_ack) begin
                        w_tcnt_next = '0;
                        case (r_state)
                            S_DC_REQ: w_state_next = S_DC_WAIT;
                            S_AC_REQ: w_state_next = S_AC_WAIT;
                            default:  w_state_next = S_SP_WAIT;
                        endcase
                    end
                end
                S_DC_WAIT, S_AC_WAIT, S_SP_WAIT: begin
                    if (bus.solve_done) begin
                        if (bus.solve_ok) begin
                            w_retry_next = '0;
                            case (r_state)
                                S_DC_WAIT: begin
                                    w_idx_next   = '0;
                                    w_state_next = (r_npts == '0) ? S_FIN : S_AC_REQ;
                                end
                                S_AC_WAIT: w_state_next = S_SP_REQ;
                                default: begin
                                    w_pts_next = r_pts + P_ONE;
                                    if (w_idx_inc == {1'b0, r_npts}) begin
                                        w_state_next = S_FIN;
                                    end else begin
                                        w_idx_next   = w_idx_inc[IDX_W-1:0];
                                        w_state_next = S_AC_REQ;
                                    end
                                end
                            endcase
                        end else if (r_retry < R_MAX) begin
                            w_retry_next = r_retry + RW'(1);
                            case (r_state)
                                S_DC_WAIT: w_state_next = S_DC_REQ;
                                S_AC_WAIT: w_state_next = S_AC_REQ;
                                default:   w_state_next = S_SP_REQ;
                            endcase
                        end else begin
                            w_state_next    = S_ERR;
                            w_err_code_next = 2'b01;
                        end
                    end else if (r_tcnt == T_LAST) begin
                        w_state_next    = S_ERR;
                        w_err_code_next = 2'b10;
                    end else begin
                        w_tcnt_next = r_tcnt + TW'(1);
                    end
                end
                S_FIN:   w_state_next = S_IDLE;
                S_ERR:   w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end

        if (w_state_next == S_ERR) begin
            w_error_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_npts       <= '0;
            r_idx        <= '0;
            r_retry      <= '0;
            r_tcnt       <= '0;
            r_pts        <= '0;
            r_error      <= 1'b0;
            r_err_code   <= 2'b00;
            r_solve_req  <= 1'b0;
            r_solve_type <= 2'b00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_npts     <= w_npts_next;
            r_idx      <= w_idx_next;
            r_retry    <= w_retry_next;
            r_tcnt     <= w_tcnt_next;
            r_pts      <= w_pts_next;
            r_error    <= w_error_next;
            r_err_code <= w_err_code_next;
            r_busy     <= (w_state_next != S_IDLE);
            r_done     <= (w_state_next == S_FIN);
            r_solve_req <= (w_state_next == S_DC_REQ) || (w_state_next == S_AC_REQ) ||
                           (w_state_next == S_SP_REQ);
            case (w_state_next)
                S_DC_REQ: r_solve_type <= 2'b00;
                S_AC_REQ: r_solve_type <= 2'b01;
                S_SP_REQ: r_solve_type <= 2'b10;
                default:  r_solve_type <= r_solve_type;
            endcase
        end
    end

    assign bus.solve_req  = r_solve_req;
    assign bus.solve_type = r_solve_type;
    assign bus.solve_idx  = r_idx;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.err_code   = r_err_code;
    assign bus.pts_done   = r_pts;

    logic w_unused;
    assign w_unused = w_is_wait;
endmodule

// File: tb/tb_stab_sweep_sched.sv
// Directed bench for stab_sweep_sched: plays the solver engine and checks request order and status.
`timescale 1ns/1ps
module tb_stab_sweep_sched;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_cnt;

    stab_sweep_if #(.IDX_W(8)) bus ();

    stab_sweep_sched #(.IDX_W(8), .MAX_RETRY(2), .TIMEOUT(1023)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic do_start(input logic [7:0] n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.npts  = n;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Engine model: wait for a request, ack it, then return a result dly+1 cycles later.
    task automatic serve(input bit ok, input int dly, output logic [1:0] t,
                         output logic [7:0] ix, output bit to);
        int n;
        n  = 0;
        to = 1'b0;
        t  = 2'b11;
        ix = 8'hff;
        while (bus.solve_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.solve_req !== 1'b1) begin
            to = 1'b1;
            return;
        end
        t  = bus.solve_type;
        ix = bus.solve_idx;
        bus.solve_ack = 1'b1;
        @(negedge clk);
        bus.solve_ack = 1'b0;
        repeat (dly) @(negedge clk);
        bus.solve_done = 1'b1;
        bus.solve_ok   = ok;
        @(negedge clk);
        bus.solve_done = 1'b0;
        bus.solve_ok   = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        if (bus.solve_req !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.error !== 1'b0 || bus.err_code !== 2'b00 || bus.pts_done !== 9'd0 ||
            bus.solve_type !== 2'b00 || bus.solve_idx !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs actual req=%b busy=%b err=%b code=%b pts=%0d", bus.solve_req,
                     bus.busy, bus.error, bus.err_code, bus.pts_done);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_req", {31'd0, bus.solve_req}, 32'd0);
    endtask

    task automatic test_sweep3();
        logic [1:0] exp_t [7] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
        logic [7:0] exp_i [7] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
        logic [1:0] t;
        logic [7:0] ix;
        bit         to;
        int         d0;
        d0 = done_cnt;
        do_start(8'd3);
        chk("sweep3_busy", {31'd0, bus.busy}, 32'd1);
        for (int k = 0; k < 7; k++) begin
            serve(1'b1, 4, t, ix, to);
            chk($sformatf("sweep3_to_%0d", k), {31'd0, to}, 32'd0);
            chk($sformatf("sweep3_type_%0d", k), {30'd0, t}, {30'd0, exp_t[k]});
            chk($sformatf("sweep3_idx_%0d", k), {24'd0, ix}, {24'd0, exp_i[k]});
        end
        repeat (3) @(negedge clk);
        chk("sweep3_done_cnt", done_cnt - d0, 32'd1);
        chk("sweep3_pts", {23'd0, bus.pts_done}, 32'd3);
        chk("sweep3_error", {31'd0, bus.error}, 32'd0);
        chk("sweep3_idle", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic test_npts0();
        logic [1:0] t;
        logic [7:0] ix;
        bit         to;
        int         d0;
        d0 = done_cnt;
        do_start(8'd0);
        serve(1'b1, 4, t, ix, to);
        chk("npts0_type", {30'd0, t}, 32'd0);
        chk("npts0_idx", {24'd0, ix}, 32'd0);
        repeat (4) @(negedge clk);
        chk("npts0_no_req", {31'd0, bus.solve_req}, 32'd0);
        chk("npts0_done_cnt", done_cnt - d0, 32'd1);
        chk("npts0_pts", {23'd0, bus.pts_done}, 32'd0);
    endtask

    task automatic test_retry();
        logic [1:0] t;
        logic [7:0] ix;
        bit         to;
        int         d0;
        d0 = done_cnt;
        do_start(8'd3);
        repeat (3) serve(1'b1, 2, t, ix, to);
        for (int k = 0; k < 3; k++) begin
            serve(1'b0, 2, t, ix, to);
            chk($sformatf("retry_ac1_type_%0d", k), {30'd0, t}, 32'd1);
            chk($sformatf("retry_ac1_idx_%0d", k), {24'd0, ix}, 32'd1);
        end
        repeat (3) @(negedge clk);
        chk("retry_error", {31'd0, bus.error}, 32'd1);
        chk("retry_code", {30'd0, bus.err_code}, 32'd1);
        chk("retry_pts", {23'd0, bus.pts_done}, 32'd1);
        chk("retry_no_done", done_cnt - d0, 32'd0);
        chk("retry_no_req", {31'd0, bus.solve_req}, 32'd0);
    endtask

    task automatic test_timeout();
        int n;
        do_start(8'd3);
        n = 0;
        while (bus.solve_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.solve_ack = 1'b1;
        @(negedge clk);
        bus.solve_ack = 1'b0;
        n = 0;
        while (bus.error !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_wait_cycles", n, 32'd1023);
        chk("timeout_code", {30'd0, bus.err_code}, 32'd2);
        chk("timeout_req_low", {31'd0, bus.solve_req}, 32'd0);
        @(negedge clk);
        chk("timeout_idle", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic test_abort();
        logic [1:0] t;
        logic [7:0] ix;
        bit         to;
        int         d0;
        int         n;
        d0 = done_cnt;
        do_start(8'd3);
        repeat (2) serve(1'b1, 2, t, ix, to);
        n = 0;
        while (bus.solve_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_sp_type", {30'd0, bus.solve_type}, 32'd2);
        bus.solve_ack = 1'b1;
        @(negedge clk);
        bus.solve_ack  = 1'b0;
        bus.solve_done = 1'b1;
        bus.solve_ok   = 1'b1;
        bus.abort      = 1'b1;
        @(negedge clk);
        bus.solve_done = 1'b0;
        bus.solve_ok   = 1'b0;
        bus.abort      = 1'b0;
        chk("abort_error", {31'd0, bus.error}, 32'd1);
        chk("abort_code", {30'd0, bus.err_code}, 32'd3);
        chk("abort_pts", {23'd0, bus.pts_done}, 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 32'd0);
        bus.abort = 1'b1;
        repeat (2) @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_idle_code", {30'd0, bus.err_code}, 32'd3);
    endtask

    task automatic test_async_reset();
        logic [1:0] t;
        logic [7:0] ix;
        bit         to;
        int         n;
        int         d0;
        do_start(8'd3);
        serve(1'b1, 2, t, ix, to);
        n = 0;
        while (bus.solve_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.solve_ack = 1'b1;
        @(negedge clk);
        bus.solve_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        if (bus.solve_req !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.error !== 1'b0 || bus.err_code !== 2'b00 || bus.pts_done !== 9'd0 ||
            bus.solve_type !== 2'b00 || bus.solve_idx !== 8'd0) begin
            errors++;
            $display("FAIL async_reset actual req=%b busy=%b type=%b pts=%0d expected all zero",
                     bus.solve_req, bus.busy, bus.solve_type, bus.pts_done);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_restart", {31'd0, bus.solve_req}, 32'd0);
        d0 = done_cnt;
        do_start(8'd1);
        serve(1'b1, 1, t, ix, to);
        chk("rst_clean_dc", {30'd0, t}, 32'd0);
        serve(1'b1, 1, t, ix, to);
        chk("rst_clean_ac", {22'd0, t, ix}, 32'h100);
        serve(1'b1, 1, t, ix, to);
        chk("rst_clean_sp", {22'd0, t, ix}, 32'h200);
        repeat (3) @(negedge clk);
        chk("rst_clean_done", done_cnt - d0, 32'd1);
        chk("rst_clean_pts", {23'd0, bus.pts_done}, 32'd1);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.npts       = 8'd0;
        bus.solve_ack  = 1'b0;
        bus.solve_done = 1'b0;
        bus.solve_ok   = 1'b0;
        test_reset();
        test_sweep3();
        test_npts0();
        test_retry();
        test_timeout();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stab_sweep_sched.md
STAB_SWEEP_SCHED -- requirements
Module: stab_sweep_sched

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- IDX_W, 8, width of the frequency-point index.
- MAX_RETRY, 2, re-issues allowed per request after a non-converged result.
- TIMEOUT, 1023, cycles allowed from ack to solve_done.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  terminate the current sweep.
- npts  in  IDX_W  number of AC/SP frequency points; captured at start.
- solve_req  out  1  request to the shared solver engine.
- solve_type  out  2  analysis type: 00 DC, 01 AC, 10 SP.
- solve_idx  out  IDX_W  frequency index of the request; 0 for DC.
- solve_ack  in  1  engine accepted the request.
- solve_done  in  1  engine result-valid pulse.
- solve_ok  in  1  converged flag; qualified by solve_done.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky failure flag; cleared by the next accepted start.
- err_code  out  2  01 non-convergence, 10 timeout, 11 aborted.
- pts_done  out  IDX_W+1  count of fully completed points (AC and SP both ok).

Function
REQ-003 States SHALL be IDLE, DC_REQ, DC_WAIT, AC_REQ, AC_WAIT, SP_REQ, SP_WAIT, FIN, ERR.
REQ-004 On start=1 in IDLE: capture npts, clear error/err_code/pts_done/idx/retry count, enter DC_REQ; solve_req SHALL be high on the next cycle.
REQ-005 start while busy SHALL be ignored.
REQ-006 In each *_REQ state:
- solve_req SHALL be 1, with solve_type/solve_idx stable.
- solve_ack=1 SHALL move to the matching *_WAIT state; solve_req is 0 from that next cycle.
REQ-007 In *_WAIT: a cycle counter, cleared on entry, SHALL increment each cycle; reaching TIMEOUT without solve_done SHALL enter ERR with err_code=10.
REQ-008 solve_done SHALL be ignored outside *_WAIT states.
REQ-009 solve_done with solve_ok=0 SHALL:
- return to the same *_REQ state with the same type/idx while retry count < MAX_RETRY;
- otherwise enter ERR with err_code=01.
The retry count SHALL clear on every solve_done with solve_ok=1.
REQ-010 Transitions on solve_done with solve_ok=1:
- DC_WAIT: to AC_REQ with idx=0, or to FIN if captured npts=0.
- AC_WAIT: to SP_REQ, same idx.
- SP_WAIT: pts_done+1, then to AC_REQ with idx+1, or to FIN if idx+1 = npts.
REQ-011 FIN SHALL assert done for exactly one cycle, then return to IDLE; busy SHALL be 1 in FIN.
REQ-012 ERR SHALL set error=1, hold err_code, drive solve_req=0, and return to IDLE next cycle; error/err_code SHALL persist in IDLE.
REQ-013 abort=1 in any non-IDLE state SHALL enter ERR with err_code=11 next cycle.
REQ-014 abort SHALL take priority over solve_done, solve_ack and timeout in the same cycle.
REQ-015 abort in IDLE SHALL have no effect.
REQ-016 solve_idx SHALL not wrap: npts=2^IDX_W-1 completes with final idx=2^IDX_W-2.
REQ-017 The timeout counter SHALL be wide enough for TIMEOUT without overflow.

Reset
REQ-018 rst_n=0 SHALL immediately force: IDLE; solve_req=0, solve_type=00, solve_idx=0, busy=0, done=0, error=0, err_code=00, pts_done=0; retry and timeout counters 0.
REQ-019 Reset mid-sweep SHALL discard all progress; the engine handshake restarts only on a new start.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- npts=3, engine acks next cycle, done ok 5 cycles later: request sequence DC/0, AC/0, SP/0, AC/1, SP/1, AC/2, SP/2; single done pulse; pts_done=3; error=0.
- npts=0: one DC request only, then done; pts_done=0.
- AC idx 1 returns solve_ok=0 three times (MAX_RETRY=2): AC/1 issued 3 times, then error=1, err_code=01, pts_done=1, no done.
- Engine acks DC but never asserts done: ERR after 1023 wait cycles, err_code=10, solve_req low.
- abort in the same cycle as solve_done ok in SP_WAIT: err_code=11, pts_done unchanged, no done pulse.
- rst_n low during AC_WAIT: all outputs at reset values asynchronously; a later start runs a clean sweep from DC.
